ov7670_capture: RTL and testbench



---
 rtl/ov7670_pkg.sv | 20 ++
 rtl/ov7670_pix_fifo.sv | 64 ++++++
 rtl/ov7670_capture.sv | 186 ++++++++++++++++++
 tb/tb_ov7670_capture.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture front end.
package ov7670_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF,
      BLANK,
      ACTIVE
   } cap_state_t;

   localparam int PIX_W = 16;

   typedef struct packed {
      logic tuser;
      logic tlast;
   } side_t;

   localparam int SIDE_W = $bits(side_t);
   localparam int FIFO_W = PIX_W + SIDE_W;

endpackage

// File: rtl/ov7670_pix_fifo.sv
// Single-clock pixel FIFO whose head entry sits in a registered output stage.
// The output register counts toward the DEPTH capacity; empty means no valid head.
module ov7670_pix_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] out_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      mem_cnt, level;
   logic             out_valid, pop, load, wr;

   assign pop   = out_valid & pop_ready;
   assign level = mem_cnt + {{AW{1'b0}}, out_valid};
   assign full  = (level == FULL_LVL);
   assign empty = ~out_valid;
   assign load  = (~out_valid | pop_ready) & (mem_cnt != '0);
   assign wr    = push & (~full | pop);

   // NOTE: storage has no reset; only pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_cnt   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (load) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
         case ({wr, load})
            2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
            2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
            default: mem_cnt <= mem_cnt;
         endcase
      end
   end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: synchronizes the sensor bus, pairs bytes into
// RGB565 pixels and emits them as a video AXI4-Stream through a small FIFO.
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             enable,
   input  logic             err_clr,
   input  logic             cam_pclk,
   input  logic             cam_vsync,
   input  logic             cam_href,
   input  logic [7:0]       cam_data,
   output logic [PIX_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tuser,
   output logic             m_axis_tlast,
   output logic             overflow,
   output logic             geom_err,
   output logic [15:0]      frame_cnt
);

   localparam int COL_W = $clog2(H_ACTIVE + 1);
   localparam int ROW_W = $clog2(V_ACTIVE + 2);
   localparam logic [COL_W-1:0] COL_END  = COL_W'(H_ACTIVE);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
   localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(V_ACTIVE);
   localparam logic [ROW_W-1:0] ROW_SAT  = ROW_W'(V_ACTIVE + 1);

   typedef struct packed {
      logic       pclk;
      logic       vsync;
      logic       href;
      logic [7:0] data;
   } cam_bus_t;

   cam_bus_t s1, s2;
   logic     s3_pclk, s3_vsync, s3_href;
   logic     pclk_rise, vsync_rise, vsync_fall, href_fall;

   // Stage s3 only feeds edge detection, so the data byte is not carried into it.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         s1       <= '0;
         s2       <= '0;
         s3_pclk  <= 1'b0;
         s3_vsync <= 1'b0;
         s3_href  <= 1'b0;
      end else begin
         s1       <= '{pclk: cam_pclk, vsync: cam_vsync, href: cam_href, data: cam_data};
         s2       <= s1;
         s3_pclk  <= s2.pclk;
         s3_vsync <= s2.vsync;
         s3_href  <= s2.href;
      end
   end

   assign pclk_rise  = s2.pclk & ~s3_pclk;
   assign vsync_rise = s2.vsync & ~s3_vsync;
   assign vsync_fall = ~s2.vsync & s3_vsync;
   assign href_fall  = ~s2.href & s3_href;

   cap_state_t       state;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             byte_phase, sof_pending;
   logic [7:0]       hi_byte;
   logic             pix_push;
   logic [PIX_W-1:0] pix_data;
   side_t            pix_side;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state       <= WAIT_SOF;
         col         <= '0;
         row         <= '0;
         byte_phase  <= 1'b0;
         sof_pending <= 1'b0;
         hi_byte     <= '0;
         pix_push    <= 1'b0;
         pix_data    <= '0;
         pix_side    <= '0;
         geom_err    <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         pix_push <= 1'b0;
         // NOTE: the clear comes first so an error event later in this block overrides it.
         if (err_clr) geom_err <= 1'b0;

         if (state != WAIT_SOF && vsync_rise) begin
            if (row != ROW_END) geom_err <= 1'b1;
            else                frame_cnt <= frame_cnt + 16'd1;
            state <= WAIT_SOF;
         end else begin
            unique case (state)
               WAIT_SOF: begin
                  if (vsync_fall && enable) begin
                     state       <= BLANK;
                     col         <= '0;
                     row         <= '0;
                     byte_phase  <= 1'b0;
                     sof_pending <= 1'b1;
                  end
               end
               BLANK: begin
                  if (pclk_rise && s2.href) begin
                     state      <= ACTIVE;
                     hi_byte    <= s2.data;
                     byte_phase <= 1'b1;
                  end
               end
               ACTIVE: begin
                  if (href_fall) begin
                     if (col != COL_END || byte_phase) geom_err <= 1'b1;
                     col        <= '0;
                     byte_phase <= 1'b0;
                     row        <= (row == ROW_SAT) ? row : row + ROW_W'(1);
                     state      <= BLANK;
                  end else if (pclk_rise && s2.href) begin
                     if (!byte_phase) begin
                        hi_byte    <= s2.data;
                        byte_phase <= 1'b1;
                     end else begin
                        byte_phase  <= 1'b0;
                        sof_pending <= 1'b0;
                        if (col == COL_END) begin
                           geom_err <= 1'b1;
                        end else begin
                           col <= col + COL_W'(1);
                           // Lines past the frame height still count geometry but emit nothing.
                           if (row < ROW_END) begin
                              pix_push <= 1'b1;
                              pix_data <= {hi_byte, s2.data};
                              pix_side <= '{tuser: sof_pending, tlast: (col == COL_LAST)};
                           end
                        end
                     end
                  end
               end
               default: state <= WAIT_SOF;
            endcase
         end
      end
   end

   logic              fifo_full, fifo_empty, axis_pop;
   logic [FIFO_W-1:0] fifo_out;
   side_t             out_side;

   ov7670_pix_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (ACLK),
      .rst       (ARESET),
      .push      (pix_push),
      .push_data ({pix_data, pix_side}),
      .pop_ready (m_axis_tready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .out_data  (fifo_out)
   );

   assign m_axis_tvalid = ~fifo_empty;
   assign m_axis_tdata  = fifo_out[FIFO_W-1 -: PIX_W];
   assign out_side      = side_t'(fifo_out[SIDE_W-1:0]);
   assign m_axis_tuser  = out_side.tuser;
   assign m_axis_tlast  = out_side.tlast;
   assign axis_pop      = m_axis_tvalid & m_axis_tready;

   // A simultaneous pop frees a slot, so only a push against a held-full FIFO is lost.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         overflow <= 1'b0;
      end else begin
         if (err_clr) overflow <= 1'b0;
         if (pix_push && fifo_full && !axis_pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture: directed camera frames push expected
// beats; an independent monitor pops and compares on each stream handshake.
module tb_ov7670_capture;

   localparam int H = 4;
   localparam int V = 2;
   localparam int D = 8;

   logic        ACLK = 1'b0;
   logic        ARESET, enable, err_clr;
   logic        cam_pclk, cam_vsync, cam_href;
   logic [7:0]  cam_data;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
   logic        overflow, geom_err;
   logic [15:0] frame_cnt;

   ov7670_capture #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .FIFO_DEPTH (D)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .enable        (enable),
      .err_clr       (err_clr),
      .cam_pclk      (cam_pclk),
      .cam_vsync     (cam_vsync),
      .cam_href      (cam_href),
      .cam_data      (cam_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .overflow      (overflow),
      .geom_err      (geom_err),
      .frame_cnt     (frame_cnt)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [15:0] data;
      logic        tuser;
      logic        tlast;
   } beat_t;

   beat_t      sb[$];
   beat_t      exp_b, held;
   logic       hold_v = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         beats_seen = 0;
   int         exp_frames = 0;
   int         b0;
   logic [7:0] next_byte = 8'h12;
   logic [7:0] r_hi, r_lo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor samples on the falling edge; the bench only moves inputs mid-way after rising edges.
   always @(negedge ACLK) begin
      if (ARESET) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("stall_tvalid", m_axis_tvalid, 1);
            check("stall_tdata", m_axis_tdata, held.data);
            check("stall_tuser", m_axis_tuser, held.tuser);
            check("stall_tlast", m_axis_tlast, held.tlast);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: actual tdata 0x%0h required no beat at %0t", m_axis_tdata, $time);
            end else begin
               exp_b = sb.pop_front();
               check("beat_tdata", m_axis_tdata, exp_b.data);
               check("beat_tuser", m_axis_tuser, exp_b.tuser);
               check("beat_tlast", m_axis_tlast, exp_b.tlast);
            end
            beats_seen++;
         end
         hold_v = m_axis_tvalid && !m_axis_tready;
         held   = '{data: m_axis_tdata, tuser: m_axis_tuser, tlast: m_axis_tlast};
      end
   end

   // One PCLK period; the sensor changes its outputs on the falling edge.
   task automatic cam_tick(input logic v, input logic h, input logic [7:0] d);
      cam_pclk  = 1'b0;
      cam_vsync = v;
      cam_href  = h;
      cam_data  = d;
      #40;
      cam_pclk  = 1'b1;
      #40;
   endtask

   task automatic blank(input int n, input logic v);
      for (int i = 0; i < n; i++) cam_tick(v, 1'b0, 8'h00);
   endtask

   task automatic frame_start();
      blank(2, 1'b1);
      blank(4, 1'b0);
   endtask

   task automatic frame_end();
      blank(2, 1'b0);
      blank(2, 1'b1);
   endtask

   // Drives nbytes on one href-high line; the first push_n pixels are expected out.
   task automatic send_line(input int nbytes, input int push_n, input bit sof);
      logic [7:0] prev, b;
      prev = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         b         = next_byte;
         next_byte = next_byte + 8'h22;
         if ((i % 2) == 1 && (i / 2) < push_n)
            sb.push_back('{data: {prev, b}, tuser: (sof && (i / 2) == 0), tlast: ((i / 2) == H - 1)});
         cam_tick(1'b0, 1'b1, b);
         prev = b;
      end
      blank(3, 1'b0);
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 400 && sb.size() != 0; k++) #10;
      #100;
      check(name, sb.size(), 0);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      #10;
      err_clr = 1'b0;
      #20;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_tvalid"}, m_axis_tvalid, 0);
      check({tag, "_tdata"}, m_axis_tdata, 0);
      check({tag, "_tuser"}, m_axis_tuser, 0);
      check({tag, "_tlast"}, m_axis_tlast, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_geom_err"}, geom_err, 0);
      check({tag, "_frame_cnt"}, frame_cnt, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESET = 1'b1; enable = 1'b1; err_clr = 1'b0;
      cam_pclk = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
      m_axis_tready = 1'b0;
      #27;
      check_reset("por");
      ARESET = 1'b0;
      #40;

      // Nominal 4x2 frame with tready held high.
      m_axis_tready = 1'b1;
      frame_start();
      send_line(8, 4, 1);
      send_line(8, 4, 0);
      frame_end();
      wait_drain("nominal_drain");
      exp_frames++;
      check("nominal_beats", beats_seen, 8);
      check("nominal_frame_cnt", frame_cnt, exp_frames);
      check("nominal_geom_err", geom_err, 0);
      check("nominal_overflow", overflow, 0);

      // One line stalled fits; a second frame fills the FIFO exactly; the third is lost.
      m_axis_tready = 1'b0;
      frame_start();
      send_line(8, 4, 1);
      check("bp_line_overflow", overflow, 0);
      m_axis_tready = 1'b1;
      send_line(8, 4, 0);
      frame_end();
      wait_drain("bp_line_drain");
      exp_frames++;
      m_axis_tready = 1'b0;
      frame_start();
      send_line(8, 4, 1);
      send_line(8, 4, 0);
      frame_end();
      exp_frames++;
      check("bp_full_overflow", overflow, 0);
      frame_start();
      send_line(8, 0, 1);
      send_line(8, 0, 0);
      frame_end();
      exp_frames++;
      check("bp_lost_overflow", overflow, 1);
      b0 = beats_seen;
      m_axis_tready = 1'b1;
      wait_drain("bp_drain");
      check("bp_delivered", beats_seen - b0, 8);
      check("bp_frame_cnt", frame_cnt, exp_frames);
      pulse_clr();
      check("bp_overflow_clr", overflow, 0);

      // Short line then a normal line.
      frame_start();
      send_line(6, 3, 1);
      check("short_geom_err", geom_err, 1);
      send_line(8, 4, 0);
      frame_end();
      wait_drain("short_drain");
      exp_frames++;
      check("short_frame_cnt", frame_cnt, exp_frames);
      pulse_clr();
      check("short_geom_clr", geom_err, 0);

      // Odd byte count: trailing byte discarded.
      frame_start();
      send_line(7, 3, 1);
      check("odd_geom_err", geom_err, 1);
      send_line(8, 4, 0);
      frame_end();
      wait_drain("odd_drain");
      exp_frames++;
      check("odd_frame_cnt", frame_cnt, exp_frames);
      pulse_clr();

      // Long line: fifth pixel dropped.
      frame_start();
      send_line(10, 4, 1);
      check("long_geom_err", geom_err, 1);
      send_line(8, 4, 0);
      frame_end();
      wait_drain("long_drain");
      exp_frames++;
      check("long_frame_cnt", frame_cnt, exp_frames);
      pulse_clr();

      // Extra line beyond the frame height: not emitted, frame not counted.
      frame_start();
      send_line(8, 4, 1);
      send_line(8, 4, 0);
      check("pre_extra_geom_err", geom_err, 0);
      send_line(8, 0, 0);
      frame_end();
      wait_drain("extra_drain");
      check("extra_geom_err", geom_err, 1);
      check("extra_frame_cnt", frame_cnt, exp_frames);
      pulse_clr();

      // Enable dropped mid-frame: this frame completes, the next is ignored.
      frame_start();
      send_line(8, 4, 1);
      enable = 1'b0;
      send_line(8, 4, 0);
      frame_end();
      wait_drain("gate_drain");
      exp_frames++;
      check("gate_frame_cnt", frame_cnt, exp_frames);
      b0 = beats_seen;
      frame_start();
      send_line(8, 0, 1);
      send_line(8, 0, 0);
      frame_end();
      #500;
      check("gated_beats", beats_seen - b0, 0);
      check("gated_frame_cnt", frame_cnt, exp_frames);
      check("gated_geom_err", geom_err, 0);
      enable = 1'b1;
      frame_start();
      send_line(8, 4, 1);
      send_line(8, 4, 0);
      frame_end();
      wait_drain("regate_drain");
      exp_frames++;
      check("regate_frame_cnt", frame_cnt, exp_frames);

      // Reset during the second pixel of a line.
      frame_start();
      r_hi = next_byte; next_byte = next_byte + 8'h22;
      r_lo = next_byte; next_byte = next_byte + 8'h22;
      sb.push_back('{data: {r_hi, r_lo}, tuser: 1'b1, tlast: 1'b0});
      cam_tick(1'b0, 1'b1, r_hi);
      cam_tick(1'b0, 1'b1, r_lo);
      cam_tick(1'b0, 1'b1, next_byte);
      next_byte = next_byte + 8'h22;
      check("pre_reset_drained", sb.size(), 0);
      ARESET = 1'b1;
      #20;
      check_reset("midline");
      sb.delete();
      ARESET = 1'b0;
      exp_frames = 0;
      #20;
      cam_tick(1'b0, 1'b1, next_byte);
      next_byte = next_byte + 8'h22;
      blank(3, 1'b0);
      frame_end();
      frame_start();
      send_line(8, 4, 1);
      send_line(8, 4, 0);
      frame_end();
      wait_drain("post_reset_drain");
      exp_frames++;
      check("post_reset_frame_cnt", frame_cnt, exp_frames);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
